prime_bracket_engine: RTL and testbench
=======================================

PRIME_BRACKET_ENGINE -- requirements
Module: prime_bracket_engine

Interface
REQ-001 SHALL have parameter W, default 14, meaning the data width of intake and both results (W >= 4).
REQ-002 SHALL have parameter TBL_DEPTH, default 32, meaning the number of small primes in the divisor table; the TBL_DEPTH-th prime squared SHALL exceed 2^W-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port give_valid, input, 1, request strobe.
REQ-006 SHALL have port intake, input, W, the request value N.
REQ-007 SHALL have port in_ready, output, 1, request accepted when give_valid and in_ready are both high.
REQ-008 SHALL have port up_prime, output, W, the smallest prime > N, or 0 if none fits in W bits.
REQ-009 SHALL have port low_prime, output, W, the largest prime < N, or 0 if none exists.
REQ-010 SHALL have port up_none, output, 1, no prime > N representable.
REQ-011 SHALL have port low_none, output, 1, no prime < N.
REQ-012 SHALL have port out_valid, output, 1, results valid.
REQ-013 SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both high.

Function
REQ-014 SHALL implement states BUILD, IDLE, SEARCH and DONE; reset enters BUILD.
REQ-015 BUILD SHALL fill the table with the first TBL_DEPTH primes (2,3,5,...) by trial division against entries already found, testing one divisor per cycle, then go to IDLE; in_ready SHALL be 0 during BUILD.
REQ-016 IDLE SHALL hold in_ready=1; on acceptance it SHALL capture N, set up candidate = N+1 and low candidate = N-1 using W+1-bit internal arithmetic, and go to SEARCH.
REQ-017 SEARCH SHALL run the up and low sides in parallel, each testing one table index k per cycle, with each side having its own k.
REQ-018 Each side's per-cycle test:
- If tbl[k]^2 > candidate, the candidate is prime and that side is done.
- Else if candidate mod tbl[k] = 0, step the candidate (up +1, low -1) and set k=0.
- Else k+1.
REQ-019 The low side SHALL finish immediately with low_prime=0 and low_none=1 when its candidate < 2.
REQ-020 The up side SHALL finish immediately with up_prime=0 and up_none=1 when its candidate > 2^W-1.
REQ-021 A done side SHALL freeze.
REQ-022 On the edge where the last side finishes, SHALL enter DONE with out_valid=1 and all result outputs registered; both sides finishing on the same edge is legal.
REQ-023 DONE SHALL hold out_valid and all results stable until out_ready=1, then clear out_valid and return to IDLE on that edge.
REQ-024 in_ready SHALL be 0 in SEARCH and DONE; give_valid outside IDLE SHALL be ignored, not queued.
REQ-025 Latency SHALL be 1 + max(up-side cycles, low-side cycles) from the acceptance edge to out_valid visible.
REQ-026 Results SHALL be cleared to 0 on acceptance of a new request.

Reset
REQ-027 On reset, SHALL set out_valid=0, in_ready=0, up_prime=0, low_prime=0, up_none=0 and low_none=0, and mark the table invalid.
REQ-028 Reset asserted in any state, including mid-BUILD or mid-SEARCH, SHALL abort the operation without producing output and restart BUILD after release.

Configuration
REQ-029 Macro PRIME_BRACKET_CYCLES_EN defined SHALL add output cycles[15:0], equal to the number of SEARCH cycles of the current result, saturating at 16'hFFFF, valid with out_valid, and reset to 0.
REQ-030 Without PRIME_BRACKET_CYCLES_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Apply reset, then release it -> in_ready=0 throughout BUILD, then 1; table entries are 2..131 for TBL_DEPTH=32.
REQ-032 Apply N=10 with out_ready=1 -> up_prime=11, low_prime=7, out_valid visible 6 cycles after the acceptance edge; cycles=5 when PRIME_BRACKET_CYCLES_EN is defined.
REQ-033 Apply N=2, then N=3 -> for N=2: up 3, low 0, low_none=1; for N=3: up 5, low 2, low_none=0.
REQ-034 Apply N=9972, then N=16383 (W=14) -> for N=9972: up 9973, low 9967; for N=16383: up 0, up_none=1, low 16381.
REQ-035 Hold out_ready=0 for 10 cycles in DONE while pulsing give_valid -> results stable, in_ready=0, pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-036 Assert reset for one cycle in mid-SEARCH -> no out_valid; outputs return to 0; BUILD reruns; the next request is correct.

Source files
------------

// File: rtl/prime_bracket_engine.sv
// prime_bracket_engine: returns the nearest primes above and below a request N.
// After reset a table of the first TBL_DEPTH primes is built by trial division.
// Each request then runs two trial-division searches in parallel against that table.
// Optional build macro PRIME_BRACKET_CYCLES_EN adds the cycles[15:0] output,
// which reports the number of SEARCH cycles spent on the current result.
//
// state  | meaning
// BUILD  | filling the divisor table, requests refused
// IDLE   | table valid, waiting for a request
// SEARCH | up and low candidate searches running in parallel
// DONE   | results held with out_valid until out_ready
module prime_bracket_engine #(
  parameter int W         = 14,
  parameter int TBL_DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         give_valid,
  input  logic [W-1:0] intake,
  output logic         in_ready,
  output logic [W-1:0] up_prime,
  output logic [W-1:0] low_prime,
  output logic         up_none,
  output logic         low_none,
  output logic         out_valid,
  input  logic         out_ready
`ifdef PRIME_BRACKET_CYCLES_EN
  ,
  output logic [15:0]  cycles
`endif
);

  localparam int CW = W + 1;
  localparam int SW = 2 * W;
  localparam int KW = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(TBL_DEPTH - 1);

  typedef enum logic [1:0] {ST_BUILD, ST_IDLE, ST_SEARCH, ST_DONE} state_t;

  state_t         r_state;
  logic [W-1:0]   r_tbl [TBL_DEPTH];
  logic           r_tbl_valid;

  logic [CW-1:0]  r_b_cand;
  logic [KW-1:0]  r_b_cnt;
  logic [KW-1:0]  r_b_j;

  logic [CW-1:0]  r_u_cand;
  logic [KW-1:0]  r_u_k;
  logic           r_u_done;
  logic [W-1:0]   r_u_res;
  logic           r_u_none;

  logic [CW-1:0]  r_l_cand;
  logic [KW-1:0]  r_l_k;
  logic           r_l_done;
  logic [W-1:0]   r_l_res;
  logic           r_l_none;

  logic           r_in_ready;
  logic           r_out_valid;
  logic [W-1:0]   r_up_prime;
  logic [W-1:0]   r_low_prime;
  logic           r_up_none;
  logic           r_low_none;
`ifdef PRIME_BRACKET_CYCLES_EN
  logic [15:0]    r_cycles;
`endif

  // Table build: a candidate is prime once every found entry up to its square root fails to divide it
  logic [W-1:0]   w_b_div;
  logic [SW-1:0]  w_b_sq;
  logic           w_b_prime;
  logic           w_b_mod0;

  assign w_b_div   = r_tbl[r_b_j];
  assign w_b_sq    = SW'(w_b_div) * SW'(w_b_div);
  assign w_b_prime = (r_b_j == r_b_cnt) || (w_b_sq > SW'(r_b_cand));
  assign w_b_mod0  = ((r_b_cand % CW'(w_b_div)) == '0);

  // Up side: bit W set means the candidate no longer fits the result width.
  // Candidates below 2 are stepped past, so a request of 0 yields 2 rather than 1.
  logic [W-1:0]   w_u_div;
  logic [SW-1:0]  w_u_sq;
  logic           w_u_oor;
  logic           w_u_small;
  logic           w_u_prime;
  logic           w_u_mod0;
  logic           w_u_fin;
  logic [W-1:0]   w_u_res;
  logic           w_u_none;

  assign w_u_div   = r_tbl[r_u_k];
  assign w_u_sq    = SW'(w_u_div) * SW'(w_u_div);
  assign w_u_oor   = r_u_cand[W];
  assign w_u_small = (r_u_cand < CW'(2));
  assign w_u_prime = !w_u_small && (w_u_sq > SW'(r_u_cand));
  assign w_u_mod0  = ((r_u_cand % CW'(w_u_div)) == '0);
  assign w_u_fin   = !r_u_done && (w_u_oor || w_u_prime);
  assign w_u_res   = r_u_done ? r_u_res  : (w_u_oor ? '0 : r_u_cand[W-1:0]);
  assign w_u_none  = r_u_done ? r_u_none : w_u_oor;

  // Low side: bit W set means N-1 wrapped below zero, treated as no candidate
  logic [W-1:0]   w_l_div;
  logic [SW-1:0]  w_l_sq;
  logic           w_l_empty;
  logic           w_l_prime;
  logic           w_l_mod0;
  logic           w_l_fin;
  logic [W-1:0]   w_l_res;
  logic           w_l_none;

  assign w_l_div   = r_tbl[r_l_k];
  assign w_l_sq    = SW'(w_l_div) * SW'(w_l_div);
  assign w_l_empty = r_l_cand[W] || (r_l_cand < CW'(2));
  assign w_l_prime = (w_l_sq > SW'(r_l_cand));
  assign w_l_mod0  = ((r_l_cand % CW'(w_l_div)) == '0);
  assign w_l_fin   = !r_l_done && (w_l_empty || w_l_prime);
  assign w_l_res   = r_l_done ? r_l_res  : (w_l_empty ? '0 : r_l_cand[W-1:0]);
  assign w_l_none  = r_l_done ? r_l_none : w_l_empty;

  logic w_all_done;
  assign w_all_done = (r_u_done || w_u_fin) && (r_l_done || w_l_fin);

  // Controller: table build, request capture, dual search and result handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_BUILD;
      r_tbl_valid <= 1'b0;
      r_b_cand    <= CW'(2);
      r_b_cnt     <= '0;
      r_b_j       <= '0;
      r_u_cand    <= '0;
      r_u_k       <= '0;
      r_u_done    <= 1'b0;
      r_u_res     <= '0;
      r_u_none    <= 1'b0;
      r_l_cand    <= '0;
      r_l_k       <= '0;
      r_l_done    <= 1'b0;
      r_l_res     <= '0;
      r_l_none    <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_up_prime  <= '0;
      r_low_prime <= '0;
      r_up_none   <= 1'b0;
      r_low_none  <= 1'b0;
`ifdef PRIME_BRACKET_CYCLES_EN
      r_cycles    <= '0;
`endif
    end else begin
      case (r_state)
        ST_BUILD: begin
          if (w_b_prime) begin
            r_tbl[r_b_cnt] <= r_b_cand[W-1:0];
            r_b_cand       <= r_b_cand + 1'b1;
            r_b_j          <= '0;
            if (r_b_cnt == K_LAST) begin
              r_tbl_valid <= 1'b1;
              r_in_ready  <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_b_cnt <= r_b_cnt + 1'b1;
            end
          end else if (w_b_mod0) begin
            r_b_cand <= r_b_cand + 1'b1;
            r_b_j    <= '0;
          end else begin
            r_b_j <= r_b_j + 1'b1;
          end
        end

        ST_IDLE: begin
          if (give_valid && r_in_ready && r_tbl_valid) begin
            r_u_cand    <= {1'b0, intake} + 1'b1;
            r_l_cand    <= {1'b0, intake} - 1'b1;
            r_u_k       <= '0;
            r_l_k       <= '0;
            r_u_done    <= 1'b0;
            r_l_done    <= 1'b0;
            r_u_res     <= '0;
            r_l_res     <= '0;
            r_u_none    <= 1'b0;
            r_l_none    <= 1'b0;
            r_up_prime  <= '0;
            r_low_prime <= '0;
            r_up_none   <= 1'b0;
            r_low_none  <= 1'b0;
            r_in_ready  <= 1'b0;
`ifdef PRIME_BRACKET_CYCLES_EN
            r_cycles    <= '0;
`endif
            r_state     <= ST_SEARCH;
          end
        end

        ST_SEARCH: begin
`ifdef PRIME_BRACKET_CYCLES_EN
          if (r_cycles != 16'hFFFF) r_cycles <= r_cycles + 16'd1;
`endif
          if (!r_u_done) begin
            if (w_u_fin) begin
              r_u_done <= 1'b1;
              r_u_res  <= w_u_res;
              r_u_none <= w_u_none;
            end else if (w_u_small || w_u_mod0) begin
              r_u_cand <= r_u_cand + 1'b1;
              r_u_k    <= '0;
            end else begin
              r_u_k <= r_u_k + 1'b1;
            end
          end
          if (!r_l_done) begin
            if (w_l_fin) begin
              r_l_done <= 1'b1;
              r_l_res  <= w_l_res;
              r_l_none <= w_l_none;
            end else if (w_l_mod0) begin
              r_l_cand <= r_l_cand - 1'b1;
              r_l_k    <= '0;
            end else begin
              r_l_k <= r_l_k + 1'b1;
            end
          end
          if (w_all_done) begin
            r_up_prime  <= w_u_res;
            r_low_prime <= w_l_res;
            r_up_none   <= w_u_none;
            r_low_none  <= w_l_none;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_BUILD;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign up_prime  = r_up_prime;
  assign low_prime = r_low_prime;
  assign up_none   = r_up_none;
  assign low_none  = r_low_none;
`ifdef PRIME_BRACKET_CYCLES_EN
  assign cycles    = r_cycles;
`endif

endmodule

// File: tb/tb_prime_bracket_engine.sv
// Scoreboard bench for prime_bracket_engine (W=14, TBL_DEPTH=32).
module tb_prime_bracket_engine;
  localparam int W    = 14;
  localparam int TD   = 32;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         give_valid;
  logic [W-1:0] intake;
  logic         in_ready;
  logic [W-1:0] up_prime;
  logic [W-1:0] low_prime;
  logic         up_none;
  logic         low_none;
  logic         out_valid;
  logic         out_ready;
`ifdef PRIME_BRACKET_CYCLES_EN
  logic [15:0]  cycles;
`endif

  prime_bracket_engine #(.W(W), .TBL_DEPTH(TD)) dut (
    .clk(clk), .reset(reset), .give_valid(give_valid), .intake(intake),
    .in_ready(in_ready), .up_prime(up_prime), .low_prime(low_prime),
    .up_none(up_none), .low_none(low_none), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef PRIME_BRACKET_CYCLES_EN
    , .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit is_prime(int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  typedef struct {
    int n;
    int up;
    int lo;
    bit upn;
    bit lon;
    int lat;
    int cyc;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(int n, int lat, int cyc);
    exp_t e;
    e.n = n; e.lat = lat; e.cyc = cyc;
    e.up = 0; e.upn = 1'b1;
    for (int m = n + 1; m <= MAXV; m++)
      if (is_prime(m)) begin e.up = m; e.upn = 1'b0; break; end
    e.lo = 0; e.lon = 1'b1;
    for (int m = n - 1; m >= 2; m--)
      if (is_prime(m)) begin e.lo = m; e.lon = 1'b0; break; end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int lat, input int cyc);
    int t;
    t = 0;
    while (!in_ready && t < 5000) begin tick(); t++; end
    chk("send_ready", in_ready, 1);
    intake     = n[W-1:0];
    give_valid = 1'b1;
    tick();
    give_valid = 1'b0;
    sb.push_back(model(n, lat, cyc));
    chk("accept_in_ready", in_ready, 0);
    chk("accept_clr_up", up_prime, 0);
    chk("accept_clr_low", low_prime, 0);
    chk("accept_clr_none", {up_none, low_none}, 0);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int lat;
    lat = 1;
    while (!out_valid && lat < 2000) begin tick(); lat++; end
    chk("result_valid", out_valid, 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    if (e.lat > 0) chk("latency", lat, e.lat);
    chk("up_prime", up_prime, e.up);
    chk("low_prime", low_prime, e.lo);
    chk("up_none", up_none, e.upn);
    chk("low_none", low_none, e.lon);
`ifdef PRIME_BRACKET_CYCLES_EN
    if (e.cyc >= 0) chk("cycles", cycles, e.cyc);
`endif
    for (int i = 0; i < hold; i++) begin
      give_valid = i[0];
      intake     = 14'd5;
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_up", up_prime, e.up);
      chk("hold_low", low_prime, e.lo);
    end
    give_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    if (hold > 0) begin
      repeat (3) begin
        tick();
        chk("no_queued_req", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc;
    int p;
    int seen;
    int rnd;
    reset      = 1'b1;
    give_valid = 1'b0;
    out_ready  = 1'b1;
    intake     = '0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_up_prime", up_prime, 0);
    chk("rst_low_prime", low_prime, 0);
    chk("rst_up_none", up_none, 0);
    chk("rst_low_none", low_none, 0);
`ifdef PRIME_BRACKET_CYCLES_EN
    chk("rst_cycles", cycles, 0);
`endif

    reset = 1'b0;
    give_valid = 1'b1;
    intake = 14'd10;
    tick();
    chk("build_in_ready", in_ready, 0);
    bc = 1;
    while (!in_ready && bc < 20000) begin
      tick();
      bc++;
      chk("build_no_valid", out_valid, 0);
    end
    give_valid = 1'b0;
    chk("build_done", in_ready, 1);
    chk("build_len", (bc > TD), 1);
    p = 2;
    for (int i = 0; i < TD; i++) begin
      while (!is_prime(p)) p++;
      chk("tbl_entry", dut.r_tbl[i], p);
      p++;
    end
    tick();
    chk("idle_no_spurious", out_valid, 0);

    send(10, 6, 5);      collect(0);
    send(2, 0, -1);      collect(0);
    send(3, 0, -1);      collect(0);
    send(9972, 0, -1);   collect(0);
    send(16383, 0, -1);  collect(0);
    send(0, 0, -1);      collect(0);
    send(1, 0, -1);      collect(0);
    send(14351, 0, -1);  collect(0);
    for (int i = 0; i < 6; i++) begin
      rnd = $urandom_range(MAXV, 0);
      send(rnd, 0, -1);
      collect(0);
    end

    out_ready = 1'b0;
    send(100, 0, -1);
    collect(10);

    send(16383, 0, -1);
    repeat (3) tick();
    chk("abort_pre_valid", out_valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_up_prime", up_prime, 0);
    chk("abort_low_prime", low_prime, 0);
    chk("abort_nones", {up_none, low_none}, 0);
    seen = 0;
    bc = 0;
    while (!in_ready && bc < 20000) begin
      tick();
      bc++;
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    chk("rebuild_len", (bc > TD), 1);
    send(9972, 0, -1);
    collect(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
